// File: rtl/fifo_word_packer_pkg.sv
// Shared types and width helpers for the fifo word packer.
//   packer_state_t : FILL collects narrow words, HOLD presents a packed beat.
//   cnt_width      : bits needed to hold a count in 0..n.
//   lane_width     : bits needed to index one of n lanes.
package packer_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } packer_state_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int lane_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_word_packer_if.sv
// Bus bundle between a show-ahead fifo, the packer, and the wide consumer.
//   fifo_data/fifo_valid : fifo head word and non-empty flag
//   fifo_ren             : pop request back to the fifo
//   flush                : request emission of the current partial beat
//   out_data/out_keep/out_last/out_valid/out_ready : wide valid/ready beat
// modport slave  : the packer side
// modport master : the environment driving the fifo side and consuming beats
interface fifo_word_packer_if #(
  parameter int IN_W  = 8,
  parameter int RATIO = 4
);

  logic [IN_W-1:0]       fifo_data;
  logic                  fifo_valid;
  logic                  fifo_ren;
  logic                  flush;
  logic [IN_W*RATIO-1:0] out_data;
  logic [RATIO-1:0]      out_keep;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;

  modport slave (
    input  fifo_data, fifo_valid, flush, out_ready,
    output fifo_ren, out_data, out_keep, out_last, out_valid
  );

  modport master (
    output fifo_data, fifo_valid, flush, out_ready,
    input  fifo_ren, out_data, out_keep, out_last, out_valid
  );

endinterface

// File: rtl/fifo_word_packer_idle_timer.sv
// Idle counter for the packer auto-flush.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : restart the count (any pop, or not collecting)
//   en         : one more idle cycle
//   expire     : single-cycle pulse on the TIMEOUT-th consecutive idle cycle
// Only instantiated when PACKER_TIMEOUT_EN is defined.
module packer_idle_timer
  import packer_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int TW = cnt_width(TIMEOUT);

  logic [TW-1:0] idle_q, idle_d;

  // Fires in the same cycle the TIMEOUT-th idle cycle is counted.
  assign expire = en & ~clr & (idle_q == TW'(TIMEOUT - 1));

  always_comb begin
    idle_d = idle_q;
    if (clr || expire) begin
      idle_d = '0;
    end else if (en) begin
      idle_d = idle_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end

endmodule

// File: rtl/fifo_word_packer.sv
// Drain stage behind a show-ahead fifo: pops IN_W-bit words and packs RATIO
// of them into one wide beat on a valid/ready interface. Partial beats leave
// on flush (and, with PACKER_TIMEOUT_EN defined, on an idle timeout) with
// out_last=1 and a lane keep mask.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fifo_word_packer_if.slave (fifo head/pop, flush, wide beat)
// Config macro: PACKER_TIMEOUT_EN enables the idle auto-flush timer.
module fifo_word_packer
  import packer_pkg::*;
#(
  parameter int IN_W    = 8,
  parameter int RATIO   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  fifo_word_packer_if.slave bus
);

  localparam int CNT_W = cnt_width(RATIO);
  localparam int OUT_W = IN_W * RATIO;

  if (RATIO < 2 || TIMEOUT < 1) begin : g_param_check
    $error("fifo_word_packer: RATIO must be >= 2 and TIMEOUT >= 1");
  end

  packer_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [OUT_W-1:0] data_q, data_d;
  logic [RATIO-1:0] keep_q, keep_d;
  logic             last_q, last_d;
  logic             flush_pend_q, flush_pend_d;
  logic             pop;
  logic             expire;
  logic             flush_req;
  logic             take;

  // Gated with rst_n so the fifo is never popped while held in reset.
  assign pop          = rst_n & bus.fifo_valid & ((state_q == FILL) | bus.out_ready);
  assign bus.fifo_ren = pop;

`ifdef PACKER_TIMEOUT_EN
  logic idle_en;
  logic idle_clr;

  assign idle_en  = (state_q == FILL) & (cnt_q != '0) & ~pop;
  assign idle_clr = pop | (state_q != FILL);

  packer_idle_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_idle_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (idle_clr),
    .en    (idle_en),
    .expire(expire)
  );
`else
  assign expire = 1'b0;
`endif

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    keep_d       = keep_q;
    last_d       = last_q;
    flush_pend_d = flush_pend_q;
    flush_req    = bus.flush | flush_pend_q | expire;
    take         = 1'b0;

    case (state_q)
      FILL: begin
        // A pending flush is consumed here whether or not it closes a beat.
        flush_pend_d = 1'b0;
        take         = flush_req & ((cnt_q != '0) | pop);
        if (pop) begin
          for (int unsigned k = 0; k < RATIO; k++) begin
            if (cnt_q == CNT_W'(k)) begin
              data_d[k*IN_W +: IN_W] = bus.fifo_data;
              keep_d[k]              = 1'b1;
            end
          end
          cnt_d = cnt_inc;
        end
        if ((pop && (cnt_inc == CNT_W'(RATIO))) || take) begin
          state_d = HOLD;
          last_d  = take;
        end
      end

      HOLD: begin
        if (bus.flush) begin
          flush_pend_d = 1'b1;
        end
        if (bus.out_ready) begin
          // Accept and restart; unused lanes are zeroed so partial beats read 0.
          state_d = FILL;
          data_d  = '0;
          keep_d  = '0;
          last_d  = 1'b0;
          cnt_d   = '0;
          if (pop) begin
            data_d[IN_W-1:0] = bus.fifo_data;
            keep_d[0]        = 1'b1;
            cnt_d            = CNT_W'(1);
          end
        end
      end

      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      data_q       <= '0;
      keep_q       <= '0;
      last_q       <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      keep_q       <= keep_d;
      last_q       <= last_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_keep  = keep_q;
  assign bus.out_last  = last_q;
  assign bus.out_valid = (state_q == HOLD);

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer (IN_W=8, RATIO=4, TIMEOUT=16).
// A queue models the show-ahead fifo; a monitor records pop cycles and
// accepted beats. Build with PACKER_TIMEOUT_EN defined to cover the timeout.
module tb_fifo_word_packer;

  localparam int IN_W    = 8;
  localparam int RATIO   = 4;
  localparam int TIMEOUT = 16;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    int          c;
  } beat_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  fifo_word_packer_if #(.IN_W(IN_W), .RATIO(RATIO)) bus ();

  fifo_word_packer #(
    .IN_W   (IN_W),
    .RATIO  (RATIO),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [7:0] fq[$];
  beat_t      beats[$];
  int         pop_cyc[$];
  int         cyc      = 0;
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic refresh();
    bus.fifo_valid = (fq.size() != 0);
    bus.fifo_data  = (fq.size() != 0) ? fq[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] w);
    fq.push_back(w);
    refresh();
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_logs();
    pop_cyc.delete();
    beats.delete();
  endtask

  // Monitor: values sampled at the edge are the pre-edge register values.
  always @(posedge clk) begin
    beat_t b;
    if (bus.fifo_ren === 1'b1) pop_cyc.push_back(cyc);
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      b.d = bus.out_data;
      b.k = bus.out_keep;
      b.l = bus.out_last;
      b.c = cyc;
      beats.push_back(b);
    end
    cyc++;
  end

  // Fifo model: head advances just after a popping edge.
  always @(posedge clk) begin
    if (bus.fifo_ren === 1'b1) begin
      #1;
      if (fq.size() != 0) void'(fq.pop_front());
      refresh();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1);
  end

  task automatic test_reset();
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    push(8'hEE);
    tick(2);
    n_checks++; if (bus.fifo_ren !== 1'b0) $display("FAIL reset_ren: got %b want 0", bus.fifo_ren); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_keep !== 4'h0) $display("FAIL reset_keep: got %h want 0", bus.out_keep); else n_pass++;
    n_checks++; if (bus.out_last !== 1'b0) $display("FAIL reset_last: got %b want 0", bus.out_last); else n_pass++;
    n_checks++; if (bus.out_data !== 32'h0) $display("FAIL reset_data: got %h want 00000000", bus.out_data); else n_pass++;
    fq.delete();
    refresh();
    clear_logs();
    rst_n = 1'b1;
    tick(3);
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL idle_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (pop_cyc.size() != 0) $display("FAIL idle_pops: got %0d want 0", pop_cyc.size()); else n_pass++;
  endtask

  task automatic test_full_beat();
    beat_t b;
    int t;
    int lastp;
    clear_logs();
    bus.out_ready = 1'b1;
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    t = 0;
    while (beats.size() < 1 && t < 20) begin tick(1); t++; end
    tick(2);
    b.d = 'x; b.k = 'x; b.l = 1'bx; b.c = -1000;
    if (beats.size() > 0) b = beats[0];
    lastp = (pop_cyc.size() > 0) ? pop_cyc[pop_cyc.size()-1] : -100;
    n_checks++; if (beats.size() != 1) $display("FAIL full_beats: got %0d want 1", beats.size()); else n_pass++;
    n_checks++; if (b.d !== 32'h04030201) $display("FAIL full_data: got %h want 04030201", b.d); else n_pass++;
    n_checks++; if (b.k !== 4'hF) $display("FAIL full_keep: got %b want 1111", b.k); else n_pass++;
    n_checks++; if (b.l !== 1'b0) $display("FAIL full_last: got %b want 0", b.l); else n_pass++;
    n_checks++; if (pop_cyc.size() != 4) $display("FAIL full_pops: got %0d want 4", pop_cyc.size()); else n_pass++;
    n_checks++; if (b.c - lastp != 1) $display("FAIL full_latency: got %0d want 1", b.c - lastp); else n_pass++;
  endtask

  task automatic test_back_to_back();
    beat_t b0, b1;
    int t;
    int span;
    clear_logs();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    t = 0;
    while (beats.size() < 2 && t < 40) begin tick(1); t++; end
    tick(2);
    b0.d = 'x; b0.k = 'x; b0.l = 1'bx; b0.c = 0;
    b1 = b0;
    if (beats.size() > 0) b0 = beats[0];
    if (beats.size() > 1) b1 = beats[1];
    span = (pop_cyc.size() == 8) ? pop_cyc[7] - pop_cyc[0] : -1;
    n_checks++; if (beats.size() != 2) $display("FAIL b2b_beats: got %0d want 2", beats.size()); else n_pass++;
    n_checks++; if (b0.d !== 32'h13121110) $display("FAIL b2b_data0: got %h want 13121110", b0.d); else n_pass++;
    n_checks++; if (b1.d !== 32'h17161514) $display("FAIL b2b_data1: got %h want 17161514", b1.d); else n_pass++;
    n_checks++; if (b1.k !== 4'hF || b1.l !== 1'b0) $display("FAIL b2b_keep_last1: got %b/%b want 1111/0", b1.k, b1.l); else n_pass++;
    n_checks++; if (pop_cyc.size() != 8) $display("FAIL b2b_pops: got %0d want 8", pop_cyc.size()); else n_pass++;
    n_checks++; if (span != 7) $display("FAIL b2b_consecutive: got span %0d want 7", span); else n_pass++;
  endtask

  task automatic test_flush();
    beat_t b;
    int t;
    clear_logs();
    bus.out_ready = 1'b1;
    push(8'hAA); push(8'hBB);
    t = 0;
    while (fq.size() != 0 && t < 20) begin tick(1); t++; end
    tick(1);
    bus.flush = 1'b1;
    tick(1);
    bus.flush = 1'b0;
    t = 0;
    while (beats.size() < 1 && t < 10) begin tick(1); t++; end
    b.d = 'x; b.k = 'x; b.l = 1'bx; b.c = 0;
    if (beats.size() > 0) b = beats[0];
    n_checks++; if (b.d !== 32'h0000BBAA) $display("FAIL flush_data: got %h want 0000bbaa", b.d); else n_pass++;
    n_checks++; if (b.k !== 4'b0011) $display("FAIL flush_keep: got %b want 0011", b.k); else n_pass++;
    n_checks++; if (b.l !== 1'b1) $display("FAIL flush_last: got %b want 1", b.l); else n_pass++;
    tick(2);
    clear_logs();
    bus.flush = 1'b1;
    tick(1);
    bus.flush = 1'b0;
    tick(6);
    n_checks++; if (beats.size() != 0) $display("FAIL empty_flush_beats: got %0d want 0", beats.size()); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL empty_flush_valid: got %b want 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_hold();
    beat_t b;
    int t;
    clear_logs();
    bus.out_ready = 1'b0;
    push(8'h21); push(8'h22); push(8'h23); push(8'h24); push(8'h25);
    t = 0;
    while (pop_cyc.size() < 4 && t < 20) begin tick(1); t++; end
    tick(1);
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL hold_valid[%0d]: got %b want 1", i, bus.out_valid); else n_pass++;
      n_checks++; if (bus.out_data !== 32'h24232221) $display("FAIL hold_data[%0d]: got %h want 24232221", i, bus.out_data); else n_pass++;
      n_checks++; if (bus.fifo_ren !== 1'b0) $display("FAIL hold_ren[%0d]: got %b want 0", i, bus.fifo_ren); else n_pass++;
      tick(1);
    end
    n_checks++; if (pop_cyc.size() != 4) $display("FAIL hold_pops: got %0d want 4", pop_cyc.size()); else n_pass++;
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.fifo_ren !== 1'b1) $display("FAIL accept_ren: got %b want 1", bus.fifo_ren); else n_pass++;
    tick(1);
    bus.flush = 1'b1;
    tick(1);
    bus.flush = 1'b0;
    t = 0;
    while (beats.size() < 2 && t < 10) begin tick(1); t++; end
    b.d = 'x; b.k = 'x; b.l = 1'bx; b.c = 0;
    if (beats.size() > 1) b = beats[1];
    n_checks++; if (beats.size() != 2) $display("FAIL hold_beats: got %0d want 2", beats.size()); else n_pass++;
    n_checks++; if (b.d !== 32'h00000025 || b.k !== 4'b0001 || b.l !== 1'b1) $display("FAIL lane0_beat: got %h/%b/%b want 00000025/0001/1", b.d, b.k, b.l); else n_pass++;
    tick(2);
  endtask

  task automatic test_timeout();
    beat_t b;
    int t;
    int p;
    clear_logs();
    bus.out_ready = 1'b1;
    push(8'h55);
    b.d = 'x; b.k = 'x; b.l = 1'bx; b.c = -1000;
`ifdef PACKER_TIMEOUT_EN
    t = 0;
    while (beats.size() < 1 && t < 40) begin tick(1); t++; end
    if (beats.size() > 0) b = beats[0];
    p = (pop_cyc.size() > 0) ? pop_cyc[0] : -100;
    n_checks++; if (b.d !== 32'h00000055) $display("FAIL tmo_data: got %h want 00000055", b.d); else n_pass++;
    n_checks++; if (b.k !== 4'b0001 || b.l !== 1'b1) $display("FAIL tmo_keep_last: got %b/%b want 0001/1", b.k, b.l); else n_pass++;
    n_checks++; if (b.c - p != 17) $display("FAIL tmo_latency: got %0d want 17", b.c - p); else n_pass++;
`else
    tick(30);
    n_checks++; if (beats.size() != 0) $display("FAIL notmo_beats: got %0d want 0", beats.size()); else n_pass++;
    bus.flush = 1'b1;
    tick(1);
    bus.flush = 1'b0;
    t = 0;
    while (beats.size() < 1 && t < 10) begin tick(1); t++; end
    if (beats.size() > 0) b = beats[0];
    p = 0;
    n_checks++; if (b.d !== 32'h00000055 || b.k !== 4'b0001 || b.l !== 1'b1) $display("FAIL notmo_flush_beat: got %h/%b/%b want 00000055/0001/1", b.d, b.k, b.l); else n_pass++;
`endif
    tick(2);
  endtask

  task automatic test_reset_mid();
    beat_t b;
    int t;
    clear_logs();
    bus.out_ready = 1'b1;
    push(8'h31); push(8'h32); push(8'h33);
    t = 0;
    while (pop_cyc.size() < 3 && t < 20) begin tick(1); t++; end
    tick(1);
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.out_keep !== 4'h0 || bus.out_data !== 32'h0) $display("FAIL midrst_clear: got %b/%h want 0000/00000000", bus.out_keep, bus.out_data); else n_pass++;
    tick(1);
    rst_n = 1'b1;
    tick(1);
    clear_logs();
    push(8'h41); push(8'h42); push(8'h43); push(8'h44);
    t = 0;
    while (beats.size() < 1 && t < 20) begin tick(1); t++; end
    tick(2);
    b.d = 'x; b.k = 'x; b.l = 1'bx; b.c = 0;
    if (beats.size() > 0) b = beats[0];
    n_checks++; if (beats.size() != 1) $display("FAIL midrst_beats: got %0d want 1", beats.size()); else n_pass++;
    n_checks++; if (b.d !== 32'h44434241) $display("FAIL midrst_data: got %h want 44434241", b.d); else n_pass++;
    n_checks++; if (b.k !== 4'hF || b.l !== 1'b0) $display("FAIL midrst_keep_last: got %b/%b want 1111/0", b.k, b.l); else n_pass++;
  endtask

  initial begin
    bus.fifo_valid = 1'b0;
    bus.fifo_data  = 8'h00;
    bus.flush      = 1'b0;
    bus.out_ready  = 1'b0;
    test_reset();
    test_full_beat();
    test_back_to_back();
    test_flush();
    test_hold();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
